// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bank: channel state encoding, the UI mode
// value that selects alarm editing, and the per-field edit step sizes.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } alarm_state_e;

  localparam logic [1:0] MODE_ALARM = 2'd1;

  localparam logic [31:0] STEP_SEC  = 32'd1;
  localparam logic [31:0] STEP_MIN  = 32'd60;
  localparam logic [31:0] STEP_HOUR = 32'd3600;
  localparam logic [31:0] STEP_DAY  = 32'd86400;

  // Seconds added or removed by one increment/decrement of an edit field.
  function automatic logic [31:0] field_step(input logic [1:0] field);
    case (field)
      2'd0:    return STEP_SEC;
      2'd1:    return STEP_MIN;
      2'd2:    return STEP_HOUR;
      default: return STEP_DAY;
    endcase
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: lifecycle state plus its alarm time. All button inputs
// arrive here as single-cycle edge pulses already qualified by the top.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int TW         = 28,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [TW-1:0] t_main_i,
  input  logic [1:0]    field_i,
  input  logic          sel_i,
  input  logic          alarm_mode_i,
  input  logic          mode_enter_i,
  input  logic          inc_edge_i,
  input  logic          dec_edge_i,
  input  logic          ss_edge_i,
  input  logic          snz_edge_i,
  output alarm_state_e  state_o,
  output logic [TW-1:0] time_o
);

  alarm_state_e  state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [TW-1:0] step;
  logic [TW:0]   ring_end;
  logic          editable;

  assign step     = TW'(field_step(field_i));
  // One extra bit so an alarm near the top of the time range does not wrap
  // its ring window back to zero and stop immediately.
  assign ring_end = {1'b0, time_q} + (TW+1)'(RING_SEC);
  assign editable = sel_i && alarm_mode_i && (state_q == ST_IDLE);

  // Next-state and next-time selection with startstop > snooze > time compare.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    time_d  = time_q;

    if (editable) begin
      if (mode_enter_i) begin
        time_d = t_main_i;
      end else if (inc_edge_i && !dec_edge_i) begin
        time_d = time_q + step;
      end else if (dec_edge_i && !inc_edge_i) begin
        time_d = time_q - step;
      end
    end

    if (ss_edge_i && alarm_mode_i && sel_i) begin
      state_d = (state_q == ST_IDLE) ? ST_ARMED : ST_IDLE;
    end else if (ss_edge_i && !alarm_mode_i && (state_q == ST_RINGING)) begin
      state_d = ST_IDLE;
    end else if (snz_edge_i && (state_q == ST_RINGING)) begin
      state_d = ST_SNOOZED;
      time_d  = time_q + TW'(SNOOZE_SEC);
    end else begin
      case (state_q)
        ST_ARMED, ST_SNOOZED: if (t_main_i >= time_q) state_d = ST_RINGING;
        ST_RINGING:           if ({1'b0, t_main_i} >= ring_end) state_d = ST_IDLE;
        default:              ;
      endcase
    end
  end

  // Channel state and alarm time registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) begin
      // NOTE: the alarm time is cleared on reset because t_alarm must read 0
      // straight after reset, not whatever the register powered up with.
      state_q <= ST_IDLE;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
    end
  end

  assign state_o = state_q;
  assign time_o  = time_q;

endmodule

// File: rtl/alarm_bank.sv
// Bank of N_CH independent alarm channels sharing one set of UI buttons.
// Buttons are level signals; each is edge-detected here and the edge pulse is
// broadcast to every channel. Snooze support is built only when the macro
// ALARM_SNOOZE_EN is defined; otherwise the snooze button is ignored.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int TW         = 28,
  parameter  int RING_SEC   = 60,
  parameter  int SNOOZE_SEC = 300,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TW-1:0]    t_main,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [1:0]       selected,
  input  logic             startstop,
  input  logic             increment,
  input  logic             decrement,
  input  logic             snooze,
  output logic [TW-1:0]    t_alarm,
  output logic [N_CH-1:0]  armed,
  output logic [N_CH-1:0]  ringing,
  output logic             timer_buzzer
);

  logic       ss_q, inc_q, dec_q;
  logic [1:0] mode_q;
  logic       ss_edge, inc_edge, dec_edge, snz_edge;
  logic       alarm_mode, mode_enter;

  alarm_state_e  ch_state [N_CH];
  logic [TW-1:0] ch_time  [N_CH];
  logic [N_CH-1:0] ch_hit;

  // Registered copies of the buttons and mode for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_q   <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      ss_q   <= startstop;
      inc_q  <= increment;
      dec_q  <= decrement;
      mode_q <= mode;
    end
  end

  assign ss_edge    = startstop & ~ss_q;
  assign inc_edge   = increment & ~inc_q;
  assign dec_edge   = decrement & ~dec_q;
  assign alarm_mode = (mode == MODE_ALARM);
  assign mode_enter = alarm_mode && (mode_q != MODE_ALARM);

`ifdef ALARM_SNOOZE_EN
  logic snz_q;

  // Registered copy of the snooze button for edge detection.
  always_ff @(posedge clk) begin
    if (reset) snz_q <= 1'b0;
    else       snz_q <= snooze;
  end

  assign snz_edge = snooze & ~snz_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snz_edge      = 1'b0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_hit[g] = (ch_sel == SEL_W'(g));

    alarm_channel #(
      .TW         (TW),
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .t_main_i     (t_main),
      .field_i      (selected),
      .sel_i        (ch_hit[g]),
      .alarm_mode_i (alarm_mode),
      .mode_enter_i (mode_enter),
      .inc_edge_i   (inc_edge),
      .dec_edge_i   (dec_edge),
      .ss_edge_i    (ss_edge),
      .snz_edge_i   (snz_edge),
      .state_o      (ch_state[g]),
      .time_o       (ch_time[g])
    );

    assign armed[g]   = (ch_state[g] == ST_ARMED) || (ch_state[g] == ST_SNOOZED);
    assign ringing[g] = (ch_state[g] == ST_RINGING);
  end

  // Alarm time of the selected channel; an out-of-range selection reads 0.
  always_comb begin
    t_alarm = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_hit[i]) t_alarm = ch_time[i];
    end
  end

  assign timer_buzzer = |ringing;

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent alarm channels (1..16).
REQ-002 SHALL have parameter TW, default 28, width in bits of time values (seconds count).
REQ-003 SHALL have parameter RING_SEC, default 60, seconds a channel rings before auto-stop.
REQ-004 SHALL have parameter SNOOZE_SEC, default 300, seconds added to a channel's alarm time on snooze.
REQ-005 SHALL have port clk, input, 1, the single clock; rising-edge active.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port t_main, input, TW, current time in seconds.
REQ-008 SHALL have port mode, input, 2, UI mode; value 1 = ALARM mode.
REQ-009 SHALL have port ch_sel, input, $clog2(N_CH) (min 1), channel being edited or toggled.
REQ-010 SHALL have port selected, input, 2, edit field: 0 sec, 1 min, 2 hour, 3 day.
REQ-011 SHALL have ports startstop, increment, decrement, snooze, input, 1 each, level button signals.
REQ-012 SHALL have port t_alarm, output, TW, alarm time of channel ch_sel.
REQ-013 SHALL have port armed, output, N_CH, per-channel ARMED-or-SNOOZED flag.
REQ-014 SHALL have port ringing, output, N_CH, per-channel RINGING flag.
REQ-015 SHALL have port timer_buzzer, output, 1, OR of ringing.

Function
REQ-016 SHALL rising-edge-detect startstop, increment, decrement, snooze against a registered copy; every action below fires once, on the cycle after the detected edge.
REQ-017 SHALL keep per channel a state: IDLE, ARMED, RINGING, SNOOZED, plus a TW-bit alarm time.
REQ-018 SHALL, when mode changes to 1 from another value and the channel at ch_sel is IDLE, load t_main into that channel's alarm time.
REQ-019 SHALL, on increment or decrement edge with mode==1 and the channel at ch_sel IDLE, add/subtract 1, 60, 3600 or 86400 per selected, modulo 2^TW; edits to non-IDLE channels are ignored.
REQ-020 SHALL treat simultaneous increment and decrement edges as no change.
REQ-021 SHALL, on startstop edge with mode==1: the channel at ch_sel moves IDLE->ARMED, ARMED/RINGING/SNOOZED->IDLE.
REQ-022 SHALL, on startstop edge with mode!=1, move every RINGING channel to IDLE and leave others unchanged.
REQ-023 SHALL move ARMED or SNOOZED to RINGING on the first cycle where t_main >= alarm time (unsigned compare).
REQ-024 SHALL move RINGING to IDLE when t_main >= alarm time + RING_SEC (sum computed at TW+1 bits, no wrap).
REQ-025 SHALL apply a snooze edge to every RINGING channel: alarm time += SNOOZE_SEC (mod 2^TW), state -> SNOOZED.
REQ-026 SHALL give startstop precedence over snooze and both over the timeout/compare transitions in the same cycle.
REQ-027 SHALL drive t_alarm, armed, ringing, timer_buzzer from registered state (zero combinational input-to-output paths except the ch_sel mux on t_alarm).

Reset
REQ-028 SHALL, while reset is high at a clock edge, set all channels IDLE, all alarm times 0, edge-detect registers 0; hence t_alarm=0, armed=0, ringing=0, timer_buzzer=0 the next cycle.
REQ-029 SHALL abort any ringing or snooze mid-operation on reset with no residual buzzer output.

Configuration
REQ-030 SHALL implement snooze only when ALARM_SNOOZE_EN is defined; without it the snooze input is ignored, SNOOZED is unreachable, and SNOOZE_SEC is unused.

Structure
REQ-031 SHALL place the state typedef, MODE_ALARM=1 constant and field step constants (1, 60, 3600, 86400) in shared package alarm_pkg.
REQ-032 SHALL implement one channel's state and time register in sub-module alarm_channel, instantiated N_CH times.

Verification
REQ-033 Reset, mode 0->1, t_main=1000, ch_sel=0 -> t_alarm=1000; two increment edges with selected=1 -> t_alarm=1120.
REQ-034 Ch0 alarm 1120 armed, t_main steps 1119->1120 -> ringing[0]=1, timer_buzzer=1 that cycle +1; t_main=1180 -> ringing[0]=0, state IDLE.
REQ-035 Ch0 and ch2 armed at 500 and 600, t_main reaches 500 -> ringing=4'b0001; startstop edge with mode=0 -> ringing=0, armed[2]=1.
REQ-036 With ALARM_SNOOZE_EN, ch1 ringing at 2000, snooze edge -> armed[1]=1, alarm time 2300, rings again at t_main=2300; without macro, snooze edge -> still ringing.
REQ-037 Alarm time 0, selected=0, decrement edge -> 2^TW-1; increment and decrement edge same cycle -> unchanged.
REQ-038 Reset asserted while ch3 ringing -> next cycle ringing=0, timer_buzzer=0, t_alarm=0.
